branch_resolve_unit: RTL and testbench

- Decode-stage branch resolver for the 5-stage MIPS pipeline. Combines a WIDTH-generic condition evaluator with a BHT of saturating counters indexed by PC.
- Condition evaluator covers beq/bne/blez/bgtz, regimm bltz/bgez/bltzal/bgezal, and special movz/movn.
- Fetch reads a prediction. Decode resolves the branch, flags mispredicts, trains the table and counts branch/mispredict events.

---
 rtl/branch_resolve_unit_pkg.sv | 28 ++
 rtl/branch_resolve_unit_if.sv | 32 +++
 rtl/branch_resolve_unit_branch_cond.sv | 79 +++++++
 rtl/branch_resolve_unit.sv | 88 ++++++++
 tb/tb_branch_resolve_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared opcode/field constants and BHT counter helper
// Imported by the condition evaluator and the resolver top.
package branch_resolve_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    localparam logic [5:0] FN_MOVZ    = 6'h0A;
    localparam logic [5:0] FN_MOVN    = 6'h0B;

    // Saturating up/down step; ctr_max is the all-ones value of the counter width.
    function automatic logic [31:0] ctr_next(input logic [31:0] ctr, input logic taken,
                                             input logic [31:0] ctr_max);
        if (taken)
            return (ctr >= ctr_max) ? ctr : ctr + 32'd1;
        return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - fetch/decode-side signal bundle for the branch resolver
// master = pipeline side driving fetch PC and decode operands; slave = resolver.
interface branch_resolve_unit_if #(
    parameter int WIDTH     = 32,
    parameter int STAT_BITS = 32
);
    logic [31:0]          f_pc;
    logic                 f_pred_taken;
    logic                 d_valid;
    logic                 d_stall;
    logic [31:0]          d_instr;
    logic [31:0]          d_pc;
    logic                 d_pred_taken;
    logic [WIDTH-1:0]     d_data1;
    logic [WIDTH-1:0]     d_data2;
    logic                 cmp_out;
    logic                 is_branch;
    logic                 link;
    logic                 mispredict;
    logic [STAT_BITS-1:0] br_total;
    logic [STAT_BITS-1:0] br_mispred;

    modport master (
        output f_pc, d_valid, d_stall, d_instr, d_pc, d_pred_taken, d_data1, d_data2,
        input  f_pred_taken, cmp_out, is_branch, link, mispredict, br_total, br_mispred
    );

    modport slave (
        input  f_pc, d_valid, d_stall, d_instr, d_pc, d_pred_taken, d_data1, d_data2,
        output f_pred_taken, cmp_out, is_branch, link, mispredict, br_total, br_mispred
    );
endinterface

// File: rtl/branch_resolve_unit_branch_cond.sv
// rtl/branch_resolve_unit_branch_cond.sv - combinational branch/conditional-move evaluator
// Decodes only opcode, rt and funct; validity and stall are handled by the caller.
module branch_cond
    import branch_resolve_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             cmp_out,
    output logic             is_branch,
    output logic             link
);

    logic [5:0] w_op;
    logic [4:0] w_rt;
    logic [5:0] w_funct;
    logic       w_d1_neg;
    logic       w_d1_zero;
    logic       w_d2_zero;
    logic       w_unused;

    assign w_op      = instr[31:26];
    assign w_rt      = instr[20:16];
    assign w_funct   = instr[5:0];
    assign w_d1_neg  = d1[WIDTH-1];
    assign w_d1_zero = (d1 == '0);
    assign w_d2_zero = (d2 == '0);
    assign w_unused  = ^{instr[25:21], instr[15:6]};

    always_comb begin
        cmp_out   = 1'b0;
        is_branch = 1'b0;
        link      = 1'b0;
        case (w_op)
            OP_BEQ: begin
                is_branch = 1'b1;
                cmp_out   = (d1 == d2);
            end
            OP_BNE: begin
                is_branch = 1'b1;
                cmp_out   = (d1 != d2);
            end
            OP_BLEZ: begin
                is_branch = 1'b1;
                cmp_out   = w_d1_neg | w_d1_zero;
            end
            OP_BGTZ: begin
                is_branch = 1'b1;
                cmp_out   = ~w_d1_neg & ~w_d1_zero;
            end
            OP_REGIMM: begin
                case (w_rt)
                    RT_BLTZ, RT_BLTZAL: begin
                        is_branch = 1'b1;
                        cmp_out   = w_d1_neg;
                        link      = (w_rt == RT_BLTZAL) & w_d1_neg;
                    end
                    RT_BGEZ, RT_BGEZAL: begin
                        is_branch = 1'b1;
                        cmp_out   = ~w_d1_neg;
                        link      = (w_rt == RT_BGEZAL) & ~w_d1_neg;
                    end
                    default: ;
                endcase
            end
            // Conditional moves report their condition but never count as branches.
            OP_SPECIAL: begin
                if (w_funct == FN_MOVZ)
                    cmp_out = w_d2_zero;
                else if (w_funct == FN_MOVN)
                    cmp_out = ~w_d2_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - decode-stage branch resolver with BHT and event counters
// BRANCH_PRED_EN enables the BHT; without it fetch always predicts not-taken.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_BITS  = 2,
    parameter int STAT_BITS = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_resolve_unit_if.slave   bus
);

    logic w_cmp;
    logic w_is_branch;
    logic w_link;
    logic w_res;
    logic w_mispredict;

    logic [STAT_BITS-1:0] r_br_total;
    logic [STAT_BITS-1:0] r_br_mispred;

    branch_cond #(.WIDTH(WIDTH)) u_cond (
        .instr     (bus.d_instr),
        .d1        (bus.d_data1),
        .d2        (bus.d_data2),
        .cmp_out   (w_cmp),
        .is_branch (w_is_branch),
        .link      (w_link)
    );

    assign w_res = bus.d_valid & ~bus.d_stall & w_is_branch;

`ifdef BRANCH_PRED_EN
    localparam int IDX_BITS = $clog2(BHT_DEPTH);
    localparam int CTR_MAX  = (1 << CTR_BITS) - 1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] r_bht [BHT_DEPTH];
    logic [IDX_BITS-1:0] w_f_idx;
    logic [IDX_BITS-1:0] w_d_idx;
    logic                w_unused;

    assign w_f_idx          = bus.f_pc[IDX_BITS+1:2];
    assign w_d_idx          = bus.d_pc[IDX_BITS+1:2];
    assign bus.f_pred_taken = r_bht[w_f_idx][CTR_BITS-1];
    assign w_mispredict     = w_res & (w_cmp != bus.d_pred_taken);
    assign w_unused         = ^{bus.f_pc, bus.d_pc};

    // Fetch reads the registered entry, so a same-cycle train is seen one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                r_bht[i] <= CTR_INIT;
        end else if (w_res) begin
            r_bht[w_d_idx] <= CTR_BITS'(ctr_next(32'(r_bht[w_d_idx]), w_cmp, 32'(CTR_MAX)));
        end
    end
`else
    logic w_unused;

    assign bus.f_pred_taken = 1'b0;
    assign w_mispredict     = w_res & w_cmp;
    assign w_unused         = ^{bus.f_pc, bus.d_pc, bus.d_pred_taken};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_total   <= '0;
            r_br_mispred <= '0;
        end else if (w_res) begin
            if (r_br_total != '1)
                r_br_total <= r_br_total + STAT_BITS'(1);
            if (w_mispredict && (r_br_mispred != '1))
                r_br_mispred <= r_br_mispred + STAT_BITS'(1);
        end
    end

    assign bus.cmp_out    = w_cmp;
    assign bus.is_branch  = w_is_branch;
    assign bus.link       = w_link;
    assign bus.mispredict = w_mispredict;
    assign bus.br_total   = r_br_total;
    assign bus.br_mispred = r_br_mispred;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - self-checking bench: default build plus a narrow build
// Both DUTs see the same stimulus; a reference model tracks counters and BHT per build.
module tb_branch_resolve_unit;

`ifdef BRANCH_PRED_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.WIDTH(32), .STAT_BITS(32)) bus_a ();
    branch_resolve_unit_if #(.WIDTH(16), .STAT_BITS(4))  bus_b ();

    branch_resolve_unit #(.WIDTH(32), .BHT_DEPTH(64), .CTR_BITS(2), .STAT_BITS(32)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    branch_resolve_unit #(.WIDTH(16), .BHT_DEPTH(8), .CTR_BITS(1), .STAT_BITS(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int n_chk = 0;
    int n_err = 0;

    int unsigned bht_a [64];
    int unsigned bht_b [8];
    longint unsigned tot_a, mis_a, tot_b, mis_b;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rt, input int fn);
        logic [31:0] w;
        w = {6'(op), 5'($urandom_range(0, 31)), 5'(rt), 10'($urandom), 6'(fn)};
        return w;
    endfunction

    // Returns {is_branch, cond, link} using signed arithmetic on a w-bit operand view.
    function automatic logic [2:0] ref_cond(input logic [31:0] ins, input logic [31:0] d1,
                                            input logic [31:0] d2, input int w);
        longint unsigned m;
        longint unsigned a;
        longint unsigned b;
        longint sa;
        int op, rt, fn;
        bit br, c, lk;
        m  = (64'd1 << w) - 1;
        a  = longint'(d1) & m;
        b  = longint'(d2) & m;
        sa = (a >= (64'd1 << (w - 1))) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
        op = int'(ins[31:26]);
        rt = int'(ins[20:16]);
        fn = int'(ins[5:0]);
        br = 0; c = 0; lk = 0;
        if (op == 4)      begin br = 1; c = (a == b); end
        else if (op == 5) begin br = 1; c = (a != b); end
        else if (op == 6) begin br = 1; c = (sa <= 0); end
        else if (op == 7) begin br = 1; c = (sa > 0); end
        else if (op == 1 && (rt == 0 || rt == 16)) begin br = 1; c = (sa < 0);  lk = (rt == 16) && c; end
        else if (op == 1 && (rt == 1 || rt == 17)) begin br = 1; c = (sa >= 0); lk = (rt == 17) && c; end
        else if (op == 0 && fn == 10) c = (b == 0);
        else if (op == 0 && fn == 11) c = (b != 0);
        return {br, c, lk};
    endfunction

    task automatic model_reset();
        foreach (bht_a[i]) bht_a[i] = 1;
        foreach (bht_b[i]) bht_b[i] = 0;
        tot_a = 0; mis_a = 0; tot_b = 0; mis_b = 0;
    endtask

    task automatic cyc(input bit rst, input bit vld, input bit stl, input bit prd,
                       input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] fpc,
                       input logic [31:0] d1, input logic [31:0] d2);
        logic [2:0] ra, rb;
        bit res_a, res_b, mp_a, mp_b, fp_a, fp_b;
        int ia, ib;
        @(negedge clk);
        reset = rst;
        bus_a.f_pc = fpc; bus_a.d_valid = vld; bus_a.d_stall = stl; bus_a.d_pred_taken = prd;
        bus_a.d_instr = ins; bus_a.d_pc = pc; bus_a.d_data1 = d1; bus_a.d_data2 = d2;
        bus_b.f_pc = fpc; bus_b.d_valid = vld; bus_b.d_stall = stl; bus_b.d_pred_taken = prd;
        bus_b.d_instr = ins; bus_b.d_pc = pc; bus_b.d_data1 = d1[15:0]; bus_b.d_data2 = d2[15:0];
        #1;
        ra    = ref_cond(ins, d1, d2, 32);
        rb    = ref_cond(ins, d1, d2, 16);
        fp_a  = PRED_EN && (bht_a[(fpc >> 2) % 64] >= 2);
        fp_b  = PRED_EN && (bht_b[(fpc >> 2) % 8] >= 1);
        res_a = vld && !stl && ra[2];
        res_b = vld && !stl && rb[2];
        mp_a  = res_a && (ra[1] != (PRED_EN ? prd : 1'b0));
        mp_b  = res_b && (rb[1] != (PRED_EN ? prd : 1'b0));
        check_eq("a_cmp_out",   64'(bus_a.cmp_out),      64'(ra[1]));
        check_eq("a_is_branch", 64'(bus_a.is_branch),    64'(ra[2]));
        check_eq("a_link",      64'(bus_a.link),         64'(ra[0]));
        check_eq("a_mispred",   64'(bus_a.mispredict),   64'(mp_a));
        check_eq("a_f_pred",    64'(bus_a.f_pred_taken), 64'(fp_a));
        check_eq("a_br_total",  64'(bus_a.br_total),     tot_a);
        check_eq("a_br_mispr",  64'(bus_a.br_mispred),   mis_a);
        check_eq("b_cmp_out",   64'(bus_b.cmp_out),      64'(rb[1]));
        check_eq("b_is_branch", 64'(bus_b.is_branch),    64'(rb[2]));
        check_eq("b_link",      64'(bus_b.link),         64'(rb[0]));
        check_eq("b_mispred",   64'(bus_b.mispredict),   64'(mp_b));
        check_eq("b_f_pred",    64'(bus_b.f_pred_taken), 64'(fp_b));
        check_eq("b_br_total",  64'(bus_b.br_total),     tot_b);
        check_eq("b_br_mispr",  64'(bus_b.br_mispred),   mis_b);
        if (rst) begin
            model_reset();
        end else begin
            ia = int'((pc >> 2) % 64);
            ib = int'((pc >> 2) % 8);
            if (res_a) begin
                if (ra[1]) bht_a[ia] = (bht_a[ia] < 3) ? bht_a[ia] + 1 : 3;
                else       bht_a[ia] = (bht_a[ia] > 0) ? bht_a[ia] - 1 : 0;
                if (tot_a < 64'hFFFF_FFFF) tot_a++;
                if (mp_a && mis_a < 64'hFFFF_FFFF) mis_a++;
            end
            if (res_b) begin
                bht_b[ib] = rb[1] ? 1 : 0;
                if (tot_b < 15) tot_b++;
                if (mp_b && mis_b < 15) mis_b++;
            end
        end
    endtask

    task automatic idle(input logic [31:0] fpc);
        cyc(0, 0, 0, 0, 32'h0, 32'h0, fpc, 32'h0, 32'h0);
    endtask

    logic [31:0] dpool [8];
    int          ops   [8];
    int          rts   [5];
    int          fns   [3];

    initial begin
        dpool = '{32'h0, 32'h5, 32'h7, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0001_8000, 32'h7FFF, 32'h8000_0000};
        ops   = '{0, 1, 4, 5, 6, 7, 2, 8};
        rts   = '{0, 1, 16, 17, 2};
        fns   = '{10, 11, 32};

        reset = 1'b1;
        bus_a.f_pc = 0; bus_a.d_valid = 0; bus_a.d_stall = 0; bus_a.d_pred_taken = 0;
        bus_a.d_instr = 0; bus_a.d_pc = 0; bus_a.d_data1 = 0; bus_a.d_data2 = 0;
        bus_b.f_pc = 0; bus_b.d_valid = 0; bus_b.d_stall = 0; bus_b.d_pred_taken = 0;
        bus_b.d_instr = 0; bus_b.d_pc = 0; bus_b.d_data1 = 0; bus_b.d_data2 = 0;
        repeat (2) @(posedge clk);
        model_reset();

        cyc(1, 0, 0, 0, 32'h0, 32'h0, 32'h3000, 32'h0, 32'h0);
        idle(32'h3000);

        cyc(0, 1, 0, 0, mk(4, 0, 0), 32'h3000, 32'h3000, 32'd5, 32'd5);
        idle(32'h3000);

        repeat (4) cyc(0, 1, 0, 0, mk(1, 1, 0), 32'h3004, 32'h3004, 32'hFFFF_FFFF, 32'h0);
        cyc(0, 1, 0, 0, mk(1, 1, 0), 32'h3004, 32'h3004, 32'h0, 32'h0);
        idle(32'h3004);

        repeat (3) cyc(0, 1, 1, 0, mk(1, 17, 0), 32'h3008, 32'h3008, 32'h0, 32'h0);
        cyc(0, 1, 0, 0, mk(1, 17, 0), 32'h3008, 32'h3008, 32'h0, 32'h0);
        idle(32'h3008);

        cyc(0, 1, 0, 0, mk(0, 0, 11), 32'h300C, 32'h300C, 32'h0, 32'd7);
        cyc(0, 1, 0, 0, mk(6, 0, 0), 32'h3010, 32'h3010, 32'h0000_8000, 32'h0);

        repeat (20) cyc(0, 1, 0, 0, mk(4, 0, 0), 32'h3014, 32'h3014, 32'd9, 32'd9);
        idle(32'h3014);

        cyc(1, 1, 0, 0, mk(4, 0, 0), 32'h3014, 32'h3014, 32'd1, 32'd1);
        idle(32'h3014);
        idle(32'h3000);

        for (int n = 0; n < 600; n++) begin
            automatic int op = ops[$urandom_range(0, 7)];
            automatic logic [31:0] ins = mk(op, rts[$urandom_range(0, 4)], fns[$urandom_range(0, 2)]);
            automatic logic [31:0] d1 = ($urandom_range(0, 3) == 0) ? $urandom : dpool[$urandom_range(0, 7)];
            automatic logic [31:0] d2 = ($urandom_range(0, 2) == 0) ? d1 : dpool[$urandom_range(0, 7)];
            automatic logic [31:0] pc = 32'h3000 + 32'($urandom_range(0, 15)) * 4;
            automatic logic [31:0] fpc = ($urandom_range(0, 1) == 0) ? pc : 32'h3000 + 32'($urandom_range(0, 15)) * 4;
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                1'($urandom), ins, pc, fpc, d1, d2);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
